hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard unit for the pipelined MIPS core. Replaces the separate bubbler/forwarder pair.
//  Tracks in-flight register writes in a DEPTH-entry shift scoreboard (entry 0 = EX, 1 = MEM, 2 = WB).
//  Raises a load-use stall for the instruction in ID.
//  Produces registered forwarding selects that are valid while that instruction sits in EX.
//  Honours branch/jump flush and keeps saturating stall/forward performance counters.
// PARAMETERS
//  AW          5   register-index width (2**AW architectural registers; register 0 is never a hazard)
//  DEPTH       3   scoreboard entries = pipeline stages after ID that can hold a pending write (>=2)
//  LOAD_AVAIL  2   lowest entry index whose load data can be forwarded (2 = from WB)
//  SW          2   forward-select width, >= clog2(DEPTH)
//  CW          16  performance-counter width
// PORTS
//  clock         in   1    pipeline clock, rising edge
//  reset_n       in   1    asynchronous, active-low reset
//  id_valid      in   1    ID holds a real instruction
//  id_rs         in   AW   source A index
//  id_rt         in   AW   source B index
//  id_use_rs     in   1    instruction reads rs
//  id_use_rt     in   1    instruction reads rt
//  id_dest       in   AW   destination index
//  id_wr_en      in   1    instruction writes id_dest
//  id_is_load    in   1    destination value comes from data memory
//  flush         in   1    taken branch/jump resolved in EX: kill ID and EX contents
//  stall         out  1    hold PC and IF/ID; insert a bubble into EX (combinational)
//  ex_valid      out  1    EX holds a real instruction (registered)
//  ex_fwd_a      out  SW   EX operand A source: 0 = register file, k = result held in scoreboard entry k
//  ex_fwd_b      out  SW   same, for operand B
//  stall_count   out  CW   cycles with stall=1; saturates at all-ones
//  fwd_count     out  CW   issues with any nonzero select; saturates at all-ones
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - all entries invalid; ex_valid=0; ex_fwd_a=ex_fwd_b=0; both counters 0.
//   - stall=0 while in reset.
//  Entry fields: {v, dest, ld}. Only v=1 with dest!=0 can match.
//  Match: entry i matches source s if v && dest==s && s!=0 and the matching id_use_* is 1.
//  Stall, per matching entry i of source s:
//   - after issue the producer moves to entry j=i+1.
//   - stall=1 if ld && j<LOAD_AVAIL (default: load in EX, consumer in ID -> exactly 1 stall cycle).
//   - stall is forced 0 when flush=1 or id_valid=0.
//  Forwarding select, computed at issue and registered:
//   - select = j of the youngest matching entry (lowest i) with j<=DEPTH-1; else 0.
//   - producer in entry DEPTH-1 has retired: the register file is write-before-read, so select=0.
//   - a younger match always wins over an older one (back-to-back writes to the same register).
//  Each rising edge, all cases:
//   - entries k=1..DEPTH-1 <= entry k-1.
//   - oldest entry is discarded.
//   - flush zeroes v of the incoming entry-1 value (kills the instruction in EX).
//  Each rising edge, entry 0 and EX outputs by case (priority order):
//   - flush=1: entry0.v=0; ex_valid=0; selects=0 (ID instruction discarded; flush beats stall).
//   - stall=1: entry0.v=0 (bubble); ex_valid=0; selects=0; ID contents held externally.
//   - else: entry0 <= {id_valid&id_wr_en, id_dest, id_is_load}; ex_valid <= id_valid;
//     ex_fwd_a/ex_fwd_b <= computed selects.
//  Counters:
//   - stall_count increments on each edge with stall=1.
//   - fwd_count increments on each issue with either select nonzero.
//   - both hold at 2**CW-1.
//  Latency: stall is same-cycle combinational; selects appear one edge after issue.
//  reset_n deasserting mid-program clears all entries; no hazard survives reset.
// TESTING
//  1. add r3 issued, next cycle sub r4,r3,r1 -> no stall; ex_fwd_a=1 while sub in EX; fwd_count=1.
//  2. lw r5 issued, next add r6,r5,r5 -> stall=1 exactly 1 cycle, bubble (ex_valid=0);
//     then add in EX with ex_fwd_a=ex_fwd_b=2; stall_count=1.
//  3. add r2; add r2; or r7,r2,r0 -> ex_fwd_a=1 (younger wins); r0 source never stalls or forwards.
//  4. lw r5 in EX, dependent in ID, flush=1 same cycle -> stall=0; next cycle ex_valid=0;
//     entry 1 invalid; no later forward from the killed load.
//  5. reset_n low mid-stream for 1 cycle -> all outputs 0 immediately;
//     first post-reset dependent on a pre-reset dest gets select 0.
//  6. CW=4 build, 20 consecutive load-use pairs -> stall_count saturates at 15 and holds.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard unit for the pipelined MIPS core. In-flight register writes are
//   tracked in a DEPTH-entry shift scoreboard (entry 0 = EX, 1 = MEM, 2 = WB).
//   It raises a combinational load-use stall for the instruction in ID. It
//   also registers forwarding selects that are valid while that instruction
//   sits in EX. A branch/jump flush kills the ID and EX contents. Two
//   saturating counters record stall cycles and forwarding issues.
//
// Ports
//   clock        in   pipeline clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   id_valid     in   ID holds a real instruction
//   id_rs/id_rt  in   source register indices
//   id_use_rs/rt in   instruction actually reads the source
//   id_dest      in   destination register index
//   id_wr_en     in   instruction writes id_dest
//   id_is_load   in   destination value comes from data memory
//   flush        in   taken branch/jump resolved in EX
//   stall        out  hold PC and IF/ID, bubble into EX (combinational)
//   ex_valid     out  EX holds a real instruction
//   ex_fwd_a/b   out  EX operand source: 0 = regfile, k = scoreboard entry k
//   stall_count  out  saturating count of stall cycles
//   fwd_count    out  saturating count of issues with any forward
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_AVAIL = 2,
    parameter int SW         = 2,
    parameter int CW         = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [AW-1:0] id_dest,
    input  logic          id_wr_en,
    input  logic          id_is_load,
    input  logic          flush,
    output logic          stall,
    output logic          ex_valid,
    output logic [SW-1:0] ex_fwd_a,
    output logic [SW-1:0] ex_fwd_b,
    output logic [CW-1:0] stall_count,
    output logic [CW-1:0] fwd_count
);

    logic          v_q    [DEPTH];
    logic [AW-1:0] dest_q [DEPTH];
    logic          ld_q   [DEPTH];

    logic          ex_valid_q;
    logic [SW-1:0] fwd_a_q;
    logic [SW-1:0] fwd_b_q;
    logic [CW-1:0] stall_count_q, stall_count_d;
    logic [CW-1:0] fwd_count_q, fwd_count_d;

    logic          haz;
    logic [SW-1:0] sel_a;
    logic [SW-1:0] sel_b;
    logic          issue;

    // Scan oldest to youngest so the youngest match is the last to assign
    // the select. A producer in the last entry has already written the
    // register file, so its select is 0.
    always_comb begin
        haz   = 1'b0;
        sel_a = '0;
        sel_b = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v_q[i] && (dest_q[i] == id_rs) && (id_rs != '0) && id_use_rs) begin
                if (ld_q[i] && ((i + 1) < LOAD_AVAIL))
                    haz = 1'b1;
                sel_a = ((i + 1) <= (DEPTH - 1)) ? SW'(i + 1) : '0;
            end
            if (v_q[i] && (dest_q[i] == id_rt) && (id_rt != '0) && id_use_rt) begin
                if (ld_q[i] && ((i + 1) < LOAD_AVAIL))
                    haz = 1'b1;
                sel_b = ((i + 1) <= (DEPTH - 1)) ? SW'(i + 1) : '0;
            end
        end
    end

    assign stall = reset_n && id_valid && !flush && haz;
    assign issue = !flush && !stall;

    always_comb begin
        stall_count_d = stall_count_q;
        fwd_count_d   = fwd_count_q;
        if (stall && !(&stall_count_q))
            stall_count_d = stall_count_q + 1'b1;
        if (issue && id_valid && ((sel_a != '0) || (sel_b != '0)) && !(&fwd_count_q))
            fwd_count_d = fwd_count_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                v_q[k]    <= 1'b0;
                dest_q[k] <= '0;
                ld_q[k]   <= 1'b0;
            end
            ex_valid_q    <= 1'b0;
            fwd_a_q       <= '0;
            fwd_b_q       <= '0;
            stall_count_q <= '0;
            fwd_count_q   <= '0;
        end else begin
            // Entry 1 receives the instruction leaving EX; a flush kills it.
            for (int k = 1; k < DEPTH; k++) begin
                v_q[k]    <= (k == 1 && flush) ? 1'b0 : v_q[k-1];
                dest_q[k] <= dest_q[k-1];
                ld_q[k]   <= ld_q[k-1];
            end
            if (issue) begin
                v_q[0]     <= id_valid && id_wr_en;
                dest_q[0]  <= id_dest;
                ld_q[0]    <= id_is_load;
                ex_valid_q <= id_valid;
                fwd_a_q    <= id_valid ? sel_a : '0;
                fwd_b_q    <= id_valid ? sel_b : '0;
            end else begin
                v_q[0]     <= 1'b0;
                dest_q[0]  <= '0;
                ld_q[0]    <= 1'b0;
                ex_valid_q <= 1'b0;
                fwd_a_q    <= '0;
                fwd_b_q    <= '0;
            end
            stall_count_q <= stall_count_d;
            fwd_count_q   <= fwd_count_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_fwd_a    = fwd_a_q;
    assign ex_fwd_b    = fwd_b_q;
    assign stall_count = stall_count_q;
    assign fwd_count   = fwd_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       id_use_rs, id_use_rt, id_wr_en, id_is_load;
    logic       flush;

    logic        stall, ex_valid;
    logic [1:0]  ex_fwd_a, ex_fwd_b;
    logic [15:0] stall_count, fwd_count;

    logic        stall4, ex_valid4;
    logic [1:0]  ex_fwd_a4, ex_fwd_b4;
    logic [3:0]  stall_count4, fwd_count4;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    hazard_scoreboard dut (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dest(id_dest), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .stall_count(stall_count), .fwd_count(fwd_count)
    );

    hazard_scoreboard #(.CW(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dest(id_dest), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .flush(flush), .stall(stall4), .ex_valid(ex_valid4),
        .ex_fwd_a(ex_fwd_a4), .ex_fwd_b(ex_fwd_b4),
        .stall_count(stall_count4), .fwd_count(fwd_count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dst,
                         input logic wr, input logic ld);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_dest    = dst;
        id_wr_en   = wr;
        id_is_load = ld;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("rst_stall", stall, 0);
        check("rst_exv", ex_valid, 0);
        check("rst_fwd", {ex_fwd_a, ex_fwd_b}, 0);
        check("rst_cnt", {stall_count, fwd_count}, 0);
        reset_n = 1'b1;
        step();

        // 1: add r3,r1,r2 ; sub r4,r3,r1
        drive(1, 1, 2, 1, 1, 3, 1, 0);
        step();
        check("t1_add_exv", ex_valid, 1);
        check("t1_add_fwd", {ex_fwd_a, ex_fwd_b}, 0);
        drive(1, 3, 1, 1, 1, 4, 1, 0);
        check("t1_stall", stall, 0);
        step();
        check("t1_fwd_a", ex_fwd_a, 1);
        check("t1_fwd_b", ex_fwd_b, 0);
        check("t1_fcnt", fwd_count, 1);
        idle(3);

        // 2: lw r5 ; add r6,r5,r5
        drive(1, 1, 0, 1, 0, 5, 1, 1);
        step();
        drive(1, 5, 5, 1, 1, 6, 1, 0);
        check("t2_stall1", stall, 1);
        step();
        check("t2_bubble", ex_valid, 0);
        check("t2_scnt", stall_count, 1);
        check("t2_stall2", stall, 0);
        step();
        check("t2_exv", ex_valid, 1);
        check("t2_fwd", {ex_fwd_a, ex_fwd_b}, {2'd2, 2'd2});
        check("t2_scnt_hold", stall_count, 1);
        check("t2_fcnt", fwd_count, 2);
        idle(3);

        // 3: add r2 ; add r2 ; or r7,r2,r0 ; lw r0 ; add r8,r0,r0
        drive(1, 1, 1, 1, 1, 2, 1, 0);
        step();
        drive(1, 1, 1, 1, 1, 2, 1, 0);
        step();
        drive(1, 2, 0, 1, 1, 7, 1, 0);
        check("t3_stall", stall, 0);
        step();
        check("t3_fwd_a", ex_fwd_a, 1);
        check("t3_fwd_b", ex_fwd_b, 0);
        check("t3_fcnt", fwd_count, 3);
        drive(1, 1, 0, 1, 0, 0, 1, 1);
        step();
        drive(1, 0, 0, 1, 1, 8, 1, 0);
        check("t3_r0_stall", stall, 0);
        step();
        check("t3_r0_fwd", {ex_fwd_a, ex_fwd_b}, 0);
        idle(3);

        // 4: lw r5 ; dependent in ID while flush
        drive(1, 1, 0, 1, 0, 5, 1, 1);
        step();
        drive(1, 5, 5, 1, 1, 6, 1, 0);
        flush = 1'b1;
        #1;
        check("t4_stall", stall, 0);
        step();
        flush = 1'b0;
        check("t4_exv", ex_valid, 0);
        check("t4_stall_after", stall, 0);
        step();
        check("t4_exv2", ex_valid, 1);
        check("t4_fwd", {ex_fwd_a, ex_fwd_b}, 0);
        check("t4_scnt", stall_count, 1);
        idle(3);

        // 5: reset in the middle of a load-use pair
        drive(1, 1, 0, 1, 0, 5, 1, 1);
        step();
        drive(1, 5, 5, 1, 1, 6, 1, 0);
        check("t5_pre_stall", stall, 1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_stall", stall, 0);
        check("t5_rst_exv", ex_valid, 0);
        check("t5_rst_cnt", {stall_count, fwd_count}, 0);
        step();
        reset_n = 1'b1;
        #1;
        check("t5_post_stall", stall, 0);
        step();
        check("t5_post_exv", ex_valid, 1);
        check("t5_post_fwd", {ex_fwd_a, ex_fwd_b}, 0);
        idle(3);

        // 6: 20 load-use pairs, CW=4 copy saturates
        for (int p = 0; p < 20; p++) begin
            drive(1, 1, 0, 1, 0, 5, 1, 1);
            step();
            drive(1, 5, 5, 1, 1, 6, 1, 0);
            step();
            step();
        end
        idle(1);
        check("t6_scnt16", stall_count, 20);
        check("t6_fcnt16", fwd_count, 20);
        check("t6_scnt4", stall_count4, 15);
        check("t6_fcnt4", fwd_count4, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
